// File: rtl/sa_ram_rwsp_param.sv
// sa_ram_rwsp_param: parametrised 1R/1W register-file RAM with a two-stage
// read pipeline (registered read address, registered output), per-lane
// write masks, optional write-to-read forwarding on address collision,
// an output-valid flag and a one-cycle collision pulse.
module sa_ram_rwsp_param #(
   parameter int DW      = 129,
   parameter int DEPTH   = 8,
   parameter int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   parameter int WE_GRAN = 129,
   parameter int BYPASS  = 1,
   localparam int NWE    = (DW + WE_GRAN - 1) / WE_GRAN
) (
   input  logic          clk,
   input  logic          rstn,
   input  logic [AW-1:0] ra,
   input  logic          re,
   input  logic          ore,
   output logic [DW-1:0] dout,
   output logic          dout_vld,
   input  logic [AW-1:0] wa,
   input  logic          we,
   input  logic [NWE-1:0] wmask,
   input  logic [DW-1:0] di,
   output logic          collision,
   input  logic [31:0]   pwrbus_ram_pd
);

   localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);
   localparam bit          BYP     = (BYPASS != 0);

   logic [DW-1:0] mem [DEPTH];

   logic [AW-1:0] ra_p1;
   logic          ra_vld_p1;
   logic [DW-1:0] lane_bits;
   logic [DW-1:0] dout_ram;
   logic [DW-1:0] sel_data;
   logic          wa_ok;
   logic          ra_ok;
   logic          coll;

   // The power bus has no functional effect; fold it into a sink net.
   logic unused_pwrbus;
   assign unused_pwrbus = ^pwrbus_ram_pd;

   assign wa_ok = ({1'b0, wa} < DEPTH_C);
   assign ra_ok = ({1'b0, ra_p1} < DEPTH_C);

   // Expand the per-lane write mask to one enable bit per data bit.
   always_comb begin
      lane_bits = '0;
      for (int i = 0; i < DW; i++) begin
         lane_bits[i] = wmask[i / WE_GRAN];
      end
   end

   // Array write: masked lanes only, never during reset, out-of-range ignored.
   always_ff @(posedge clk) begin
      if (rstn && we && wa_ok) begin
         mem[wa] <= (mem[wa] & ~lane_bits) | (di & lane_bits);
      end
   end

   // Asynchronous array read; addresses past the last entry read as zero.
   assign dout_ram = ra_ok ? mem[ra_p1] : '0;

   // A same-edge write to the address being loaded into dout.
   assign coll = ore & we & ra_vld_p1 & (wa == ra_p1) & wa_ok;

   // Forward written lanes into the output on collision when enabled.
   always_comb begin
      sel_data = dout_ram;
      if (coll && BYP) begin
         sel_data = (di & lane_bits) | (dout_ram & ~lane_bits);
      end
   end

   // ---- stage 1: read-address capture ----
   // Register the read address; the valid flag is sticky until reset.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         ra_p1     <= '0;
         ra_vld_p1 <= 1'b0;
      end else if (re) begin
         ra_p1     <= ra;
         ra_vld_p1 <= 1'b1;
      end
   end

   // ---- stage 2: output register ----
   // Load read data and its validity when the output enable is asserted.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         dout     <= '0;
         dout_vld <= 1'b0;
      end else if (ore) begin
         dout     <= sel_data;
         dout_vld <= ra_vld_p1;
      end
   end

   // Collision pulse, re-evaluated every edge so it lasts one cycle.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         collision <= 1'b0;
      end else begin
         collision <= coll;
      end
   end

endmodule

// File: tb/tb_sa_ram_rwsp_param.sv
// Directed bench for sa_ram_rwsp_param: two instances (forwarding on/off)
// share one stimulus stream; DEPTH=6 and 32-bit write lanes exercise the
// out-of-range and narrow-last-lane cases.
module tb_sa_ram_rwsp_param;

   localparam int DW = 129;
   localparam int AW = 3;
   localparam int NWE = 5;

   localparam logic [DW-1:0] ONES = {DW{1'b1}};
   localparam logic [DW-1:0] ZERO = '0;
   localparam logic [DW-1:0] P    = 129'h1_DEADBEEF_01234567_89ABCDEF_CAFEF00D;
   localparam logic [DW-1:0] A    = 129'h0_11111111_22222222_33333333_44444444;
   localparam logic [DW-1:0] B    = 129'h1_55555555_66666666_77777777_88888888;
   localparam logic [DW-1:0] M5A  = 129'h1_FFFFFFFF_00000000_FFFFFFFF_00000000;
   localparam logic [DW-1:0] M5B  = 129'h0_FFFFFFFF_00000000_FFFFFFFF_00000000;
   localparam logic [DW-1:0] BA   = 129'h1_55555555_66666666_33333333_88888888;

   logic          clk;
   logic          rstn;
   logic [AW-1:0] ra;
   logic          re;
   logic          ore;
   logic [AW-1:0] wa;
   logic          we;
   logic [NWE-1:0] wmask;
   logic [DW-1:0] di;
   logic [31:0]   pwrbus;
   logic [DW-1:0] dout1, dout0;
   logic          vld1, vld0, coll1, coll0;

   int checks;
   int fails;

   sa_ram_rwsp_param #(.DW(DW), .DEPTH(6), .WE_GRAN(32), .BYPASS(1)) u_byp (
      .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
      .dout(dout1), .dout_vld(vld1), .wa(wa), .we(we), .wmask(wmask),
      .di(di), .collision(coll1), .pwrbus_ram_pd(pwrbus));

   sa_ram_rwsp_param #(.DW(DW), .DEPTH(6), .WE_GRAN(32), .BYPASS(0)) u_nobyp (
      .clk(clk), .rstn(rstn), .ra(ra), .re(re), .ore(ore),
      .dout(dout0), .dout_vld(vld0), .wa(wa), .we(we), .wmask(wmask),
      .di(di), .collision(coll0), .pwrbus_ram_pd(pwrbus));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic          rstn, re, ore, we;
      logic [AW-1:0] ra, wa;
      logic [NWE-1:0] wmask;
      logic [DW-1:0] di;
      logic [DW-1:0] e_dout1, e_dout0;
      logic          e_vld, e_coll;
   } vec_t;

   vec_t tbl[$];

   function automatic logic [DW-1:0] dat(input int i);
      logic [3:0] n;
      n = i[3:0];
      return {n[0], {4{28'hC0FFEE0, n}}};
   endfunction

   task automatic add(input logic r, input logic rd, input logic [AW-1:0] rda,
                      input logic o, input logic w, input logic [AW-1:0] wra,
                      input logic [NWE-1:0] m, input logic [DW-1:0] d,
                      input logic [DW-1:0] e1, input logic [DW-1:0] e0,
                      input logic ev, input logic ec);
      vec_t v;
      v.rstn = r; v.re = rd; v.ra = rda; v.ore = o; v.we = w; v.wa = wra;
      v.wmask = m; v.di = d; v.e_dout1 = e1; v.e_dout0 = e0;
      v.e_vld = ev; v.e_coll = ec;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic r, input logic rd, input logic [AW-1:0] rda,
                        input logic o, input logic w, input logic [AW-1:0] wra,
                        input logic [NWE-1:0] m, input logic [DW-1:0] d);
      rstn = r; re = rd; ra = rda; ore = o; we = w; wa = wra; wmask = m; di = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic [DW-1:0] e1, input logic [DW-1:0] e0,
                          input logic ev, input logic ec);
      chk({tag, " dout byp"},   dout1, e1);
      chk({tag, " dout nobyp"}, dout0, e0);
      chk({tag, " vld byp"},    {{(DW-1){1'b0}}, vld1},  {{(DW-1){1'b0}}, ev});
      chk({tag, " vld nobyp"},  {{(DW-1){1'b0}}, vld0},  {{(DW-1){1'b0}}, ev});
      chk({tag, " coll byp"},   {{(DW-1){1'b0}}, coll1}, {{(DW-1){1'b0}}, ec});
      chk({tag, " coll nobyp"}, {{(DW-1){1'b0}}, coll0}, {{(DW-1){1'b0}}, ec});
   endtask

   initial begin
      checks = 0;
      fails  = 0;
      pwrbus = 32'hA5A5_0F0F;
      drive(1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0, 5'h00, ZERO);

      //   rstn re ra   ore we wa   mask    di    dout(byp) dout(nobyp) vld coll
      // reset with every enable high: outputs cleared, write blocked
      add(0, 1, 3'd3, 1, 1, 3'd3, 5'h1F, ONES, ZERO, ZERO, 0, 0);
      add(0, 1, 3'd3, 1, 1, 3'd3, 5'h1F, ONES, ZERO, ZERO, 0, 0);
      // fill M[0..5], then M[3]=P
      for (int i = 0; i < 6; i++)
         add(1, 0, 3'd0, 0, 1, 3'(i), 5'h1F, dat(i), ZERO, ZERO, 0, 0);
      add(1, 0, 3'd0, 0, 1, 3'd3, 5'h1F, P, ZERO, ZERO, 0, 0);
      // second reset attempting to overwrite M[3]
      add(0, 1, 3'd3, 1, 1, 3'd3, 5'h1F, ONES, ZERO, ZERO, 0, 0);
      // ore before any re: data of ra_d=0 but not valid
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, dat(0), dat(0), 0, 0);
      // re ra=3 at N, ore at N+1
      add(1, 1, 3'd3, 0, 0, 3'd0, 5'h00, ZERO, dat(0), dat(0), 0, 0);
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, P, P, 1, 0);
      // lane masks on M[5]
      add(1, 1, 3'd5, 0, 0, 3'd0, 5'h00, ZERO, P, P, 1, 0);
      add(1, 0, 3'd5, 0, 1, 3'd5, 5'h1F, ONES, P, P, 1, 0);
      add(1, 0, 3'd5, 0, 1, 3'd5, 5'h05, ZERO, P, P, 1, 0);
      add(1, 0, 3'd5, 1, 0, 3'd0, 5'h00, ZERO, M5A, M5A, 1, 0);
      add(1, 0, 3'd5, 0, 1, 3'd5, 5'h10, ZERO, M5A, M5A, 1, 0);
      add(1, 0, 3'd5, 1, 0, 3'd0, 5'h00, ZERO, M5B, M5B, 1, 0);
      // out of range: write wa=6, read ra=6, no collision past DEPTH
      add(1, 1, 3'd6, 0, 1, 3'd6, 5'h1F, ONES, M5B, M5B, 1, 0);
      add(1, 0, 3'd0, 1, 1, 3'd7, 5'h1F, ONES, ZERO, ZERO, 1, 0);
      add(1, 0, 3'd0, 1, 1, 3'd6, 5'h1F, ONES, ZERO, ZERO, 1, 0);
      // re and we to the same address at one edge
      add(1, 1, 3'd1, 0, 1, 3'd1, 5'h1F, A, ZERO, ZERO, 1, 0);
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, A, A, 1, 0);
      // re and ore together: ore loads previous ra_d
      add(1, 1, 3'd2, 1, 0, 3'd0, 5'h00, ZERO, A, A, 1, 0);
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, dat(2), dat(2), 1, 0);
      // full-mask collision on ra_d=2
      add(1, 0, 3'd0, 1, 1, 3'd2, 5'h1F, B, B, dat(2), 1, 1);
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, B, B, 1, 0);
      // partial-mask collision: only lane 1 forwarded
      add(1, 0, 3'd0, 1, 1, 3'd2, 5'h02, A, BA, B, 1, 1);
      add(1, 0, 3'd0, 0, 1, 3'd2, 5'h00, ONES, BA, B, 1, 0);
      add(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO, BA, BA, 1, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rstn, tbl[i].re, tbl[i].ra, tbl[i].ore, tbl[i].we,
               tbl[i].wa, tbl[i].wmask, tbl[i].di);
         step();
         chk_all($sformatf("vec%0d", i), tbl[i].e_dout1, tbl[i].e_dout0,
                 tbl[i].e_vld, tbl[i].e_coll);
      end

      // streaming: refill, then one read per cycle with 2-cycle latency
      for (int i = 0; i < 6; i++) begin
         drive(1, 0, 3'd0, 0, 1, 3'(i), 5'h1F, dat(i));
         step();
      end
      for (int c = 0; c < 10; c++) begin
         drive(1, (c < 8), 3'(c), 1, 0, 3'd0, 5'h00, ZERO);
         step();
         if (c >= 1 && c <= 8)
            chk_all($sformatf("stream%0d", c), (c - 1 < 6) ? dat(c - 1) : ZERO,
                    (c - 1 < 6) ? dat(c - 1) : ZERO, 1, 0);
      end

      // mid-stream reset, then validity returns only after re then ore
      drive(1, 1, 3'd0, 1, 0, 3'd0, 5'h00, ZERO);
      step();
      drive(1, 1, 3'd1, 1, 0, 3'd0, 5'h00, ZERO);
      step();
      chk_all("midrst pre", dat(0), dat(0), 1, 0);
      drive(0, 1, 3'd2, 1, 0, 3'd0, 5'h00, ZERO);
      step();
      chk_all("midrst rst", ZERO, ZERO, 0, 0);
      drive(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO);
      step();
      chk_all("midrst ore only", dat(0), dat(0), 0, 0);
      drive(1, 1, 3'd4, 0, 0, 3'd0, 5'h00, ZERO);
      step();
      chk_all("midrst re", dat(0), dat(0), 0, 0);
      drive(1, 0, 3'd0, 1, 0, 3'd0, 5'h00, ZERO);
      step();
      chk_all("midrst ore", dat(4), dat(4), 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
